// File: rtl/time_counter_ud.sv
`default_nettype none
// ============================================================================
//  Module   : time_counter_ud
//  Purpose  : Parametrised up/down time-field counter (sec/min/hour/day).
//             Provides a programmable lower bound, a live inclusive upper bound,
//             parallel load, carry-free adjust inputs, wrap-or-saturate
//             behaviour and automatic correction when max drops below the
//             current value.
//  Ports    : clock        - rising-edge clock
//             reset        - asynchronous active-high reset
//             max          - live upper bound (inclusive)
//             tick_up      - counting increment, may produce carry_flag
//             tick_down    - counting decrement, may produce borrow_flag
//             adjust_up    - setting increment, never produces a flag
//             adjust_down  - setting decrement, never produces a flag
//             load         - parallel load strobe
//             load_value   - value to load (clamped into [VALUE_MIN, max])
//             data_out     - registered field value
//             carry_flag   - one-cycle pulse on up-wrap
//             borrow_flag  - one-cycle pulse on down-wrap
//             at_max       - data_out >= max (combinational)
//             at_min       - data_out <= VALUE_MIN (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module time_counter_ud #(
  parameter int BUS_WIDTH  = 6,
  parameter int VALUE_INIT = 0,
  parameter int VALUE_MIN  = 0,
  parameter int WRAP       = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] max,
  input  logic                 tick_up,
  input  logic                 tick_down,
  input  logic                 adjust_up,
  input  logic                 adjust_down,
  input  logic                 load,
  input  logic [BUS_WIDTH-1:0] load_value,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 carry_flag,
  output logic                 borrow_flag,
  output logic                 at_max,
  output logic                 at_min
);

  localparam logic [BUS_WIDTH-1:0] C_MIN  = BUS_WIDTH'(VALUE_MIN);
  localparam logic [BUS_WIDTH-1:0] C_INIT = BUS_WIDTH'(VALUE_INIT);
  localparam logic                 C_WRAP = (WRAP != 0);

  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 carry_q, carry_d;
  logic                 borrow_q, borrow_d;

  logic                 w_illegal;
  logic                 w_tick_act;
  logic                 w_adj_act;
  logic [BUS_WIDTH-1:0] w_up_next;
  logic [BUS_WIDTH-1:0] w_dn_next;
  logic                 w_up_wrap;
  logic                 w_dn_wrap;
  logic [BUS_WIDTH-1:0] w_load_clamped;

  // A bound of zero can never be undercut by an unsigned max, so the check
  // is only built when the lower bound is non-zero.
  generate
    if (VALUE_MIN == 0) begin : g_no_illegal
      assign w_illegal = 1'b0;
    end else begin : g_illegal
      assign w_illegal = (max < C_MIN);
    end
  endgenerate

  assign at_max = (data_q >= max);
  assign at_min = (data_q <= C_MIN);

  // Opposing requests cancel; the pair falls through to the next priority.
  assign w_tick_act = tick_up ^ tick_down;
  assign w_adj_act  = adjust_up ^ adjust_down;

  // Step results shared by tick and adjust paths. Values above max count as
  // at_max, so the +1 can never overflow the bus.
  assign w_up_wrap = at_max & C_WRAP;
  assign w_dn_wrap = at_min & C_WRAP;
  assign w_up_next = at_max ? (C_WRAP ? C_MIN : max)    : (data_q + 1'b1);
  assign w_dn_next = at_min ? (C_WRAP ? max   : data_q) : (data_q - 1'b1);

  assign w_load_clamped = (load_value <= C_MIN) ? C_MIN :
                          ((load_value > max) ? max : load_value);

  always_comb begin
    data_d   = data_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (w_illegal) begin
      data_d = C_MIN;
    end else if (load) begin
      data_d = w_load_clamped;
    end else if (w_tick_act) begin
      if (tick_up) begin
        data_d  = w_up_next;
        carry_d = w_up_wrap;
      end else begin
        data_d   = w_dn_next;
        borrow_d = w_dn_wrap;
      end
    end else if (w_adj_act) begin
      data_d = adjust_up ? w_up_next : w_dn_next;
    end else if (data_q > max) begin
      // Live bound fell below the held value (e.g. day 31, month of 30).
      data_d = max;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q   <= C_INIT;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign data_out    = data_q;
  assign carry_flag  = carry_q;
  assign borrow_flag = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_time_counter_ud.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_counter_ud
//  Purpose  : Scoreboard bench for time_counter_ud. Three instances share the
//             stimulus: A (min 0, wrap), B (min 0, saturate), C (min 1, wrap,
//             init 1). A reference model predicts each edge's outcome.
//  Revision : 1.0  initial release
// ============================================================================
module tb_time_counter_ud;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] max = 6'd59;
  logic       tick_up = 1'b0, tick_down = 1'b0;
  logic       adjust_up = 1'b0, adjust_down = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_value = 6'd0;

  logic [5:0] dout [3];
  logic       cflg [3];
  logic       bflg [3];
  logic       amax [3];
  logic       amin [3];

  int mins  [3] = '{0, 0, 1};
  int wraps [3] = '{1, 0, 1};
  int inits [3] = '{0, 0, 1};
  int state [3];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0][5:0] d;
    logic [2:0]      c;
    logic [2:0]      b;
    logic [5:0]      mx;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  time_counter_ud #(.BUS_WIDTH(6), .VALUE_INIT(0), .VALUE_MIN(0), .WRAP(1)) u_a (
    .clock(clock), .reset(reset), .max(max), .tick_up(tick_up), .tick_down(tick_down),
    .adjust_up(adjust_up), .adjust_down(adjust_down), .load(load), .load_value(load_value),
    .data_out(dout[0]), .carry_flag(cflg[0]), .borrow_flag(bflg[0]),
    .at_max(amax[0]), .at_min(amin[0]));

  time_counter_ud #(.BUS_WIDTH(6), .VALUE_INIT(0), .VALUE_MIN(0), .WRAP(0)) u_b (
    .clock(clock), .reset(reset), .max(max), .tick_up(tick_up), .tick_down(tick_down),
    .adjust_up(adjust_up), .adjust_down(adjust_down), .load(load), .load_value(load_value),
    .data_out(dout[1]), .carry_flag(cflg[1]), .borrow_flag(bflg[1]),
    .at_max(amax[1]), .at_min(amin[1]));

  time_counter_ud #(.BUS_WIDTH(6), .VALUE_INIT(1), .VALUE_MIN(1), .WRAP(1)) u_c (
    .clock(clock), .reset(reset), .max(max), .tick_up(tick_up), .tick_down(tick_down),
    .adjust_up(adjust_up), .adjust_down(adjust_down), .load(load), .load_value(load_value),
    .data_out(dout[2]), .carry_flag(cflg[2]), .borrow_flag(bflg[2]),
    .at_max(amax[2]), .at_min(amin[2]));

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference behaviour of one field for one edge, straight from the rules:
  // illegal bound, load clamp, tick (flagged), adjust (unflagged), correction.
  function automatic void model_step(input int mn, input int wr, input int mx,
                                     input int cur, input int tu, input int td,
                                     input int au, input int ad, input int ld,
                                     input int lv, output int nxt,
                                     output int c, output int b);
    int dir;
    int flagged;
    c = 0; b = 0; dir = 0; flagged = 0;
    if (mx < mn) begin
      nxt = mn;
    end else if (ld != 0) begin
      nxt = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
    end else begin
      if (tu != td) begin
        dir = (tu != 0) ? 1 : -1;
        flagged = 1;
      end else if (au != ad) begin
        dir = (au != 0) ? 1 : -1;
      end
      if (dir == 1) begin
        if (cur >= mx) begin
          if (wr != 0) begin nxt = mn; c = flagged; end
          else nxt = mx;
        end else nxt = cur + 1;
      end else if (dir == -1) begin
        if (cur <= mn) begin
          if (wr != 0) begin nxt = mx; b = flagged; end
          else nxt = cur;
        end else nxt = cur - 1;
      end else begin
        nxt = (cur > mx) ? mx : cur;
      end
    end
  endfunction

  task automatic do_cycle(input int mx, input bit tu, input bit td, input bit au,
                          input bit ad, input bit ld, input int lv);
    exp_t e;
    int nx, c, b;
    @(negedge clock);
    max = 6'(mx); tick_up = tu; tick_down = td;
    adjust_up = au; adjust_down = ad; load = ld; load_value = 6'(lv);
    e = '0;
    e.mx = 6'(mx);
    for (int i = 0; i < 3; i++) begin
      model_step(mins[i], wraps[i], mx, state[i], int'(tu), int'(td), int'(au),
                 int'(ad), int'(ld), lv, nx, c, b);
      state[i] = nx;
      e.d[i] = 6'(nx);
      e.c[i] = c[0];
      e.b[i] = b[0];
    end
    exp_q.push_back(e);
  endtask

  // Monitor: every edge each instance presents a new value; compare it.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("data[%0d]", i), int'(dout[i]), int'(e.d[i]));
        check($sformatf("carry[%0d]", i), int'(cflg[i]), int'(e.c[i]));
        check($sformatf("borrow[%0d]", i), int'(bflg[i]), int'(e.b[i]));
        check($sformatf("at_max[%0d]", i), int'(amax[i]), int'(e.d[i] >= e.mx));
        check($sformatf("at_min[%0d]", i), int'(amin[i]), int'(int'(e.d[i]) <= mins[i]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) state[i] = inits[i];
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_data[%0d]", i), int'(dout[i]), inits[i]);
      check($sformatf("reset_carry[%0d]", i), int'(cflg[i]), 0);
    end
    @(negedge clock);
    reset = 1'b0;

    // Value 30 ticking, then an asynchronous reset in the middle of a cycle.
    do_cycle(59, 0, 0, 0, 0, 1, 30);
    do_cycle(59, 1, 0, 0, 0, 0, 0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    tick_up = 1'b0; load = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_reset_data[%0d]", i), int'(dout[i]), inits[i]);
      check($sformatf("async_reset_carry[%0d]", i), int'(cflg[i]), 0);
      check($sformatf("async_reset_borrow[%0d]", i), int'(bflg[i]), 0);
      state[i] = inits[i];
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    do_cycle(59, 1, 0, 0, 0, 0, 0);          // first tick after release

    // Up-wrap with carry, down-wrap with borrow, saturation on B.
    do_cycle(59, 0, 0, 0, 0, 1, 58);
    do_cycle(59, 1, 0, 0, 0, 0, 0);
    do_cycle(59, 1, 0, 0, 0, 0, 0);
    do_cycle(59, 0, 0, 0, 0, 0, 0);
    do_cycle(59, 0, 0, 0, 0, 1, 0);
    do_cycle(59, 0, 1, 0, 0, 0, 0);
    do_cycle(59, 0, 0, 0, 0, 1, 59);
    do_cycle(59, 1, 0, 0, 0, 0, 0);

    // Load priority and clamping.
    do_cycle(59, 1, 0, 0, 0, 1, 45);
    do_cycle(59, 0, 0, 0, 0, 1, 63);
    do_cycle(59, 0, 0, 0, 0, 1, 0);

    // Adjust paths and request cancellation.
    do_cycle(59, 0, 0, 0, 0, 1, 59);
    do_cycle(59, 0, 0, 1, 0, 0, 0);
    do_cycle(59, 0, 0, 0, 0, 1, 20);
    do_cycle(59, 1, 1, 0, 0, 0, 0);
    do_cycle(59, 1, 0, 0, 1, 0, 0);
    do_cycle(59, 0, 0, 0, 1, 0, 0);
    do_cycle(59, 0, 0, 1, 1, 0, 0);

    // Day field: max falls below value, with and without a tick; illegal max.
    do_cycle(31, 0, 0, 0, 0, 1, 31);
    do_cycle(30, 0, 0, 0, 0, 0, 0);
    do_cycle(31, 0, 0, 0, 0, 1, 31);
    do_cycle(30, 1, 0, 0, 0, 0, 0);
    do_cycle(0, 1, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 1, 0, 0, 0, 0);
    do_cycle(31, 0, 0, 0, 0, 0, 0);

    // Randomised traffic with an occasionally changing bound.
    for (int n = 0; n < 3000; n++) begin
      int mx;
      int r;
      mx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : 59;
      r  = int'($urandom_range(0, 99));
      do_cycle(mx,
               r < 45 || (r >= 90 && r < 93),
               (r >= 45 && r < 70) || (r >= 90 && r < 93),
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 24) == 0,
               int'($urandom_range(0, 63)));
    end

    do_cycle(59, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
